// File: rtl/core_pkg.sv
// Shared core types: ALU opcodes, branch funct3 encodings and the branch
// sequencer state encoding.
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011
  } alu_op_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_TGT  = 2'd2,
    ST_RESP = 2'd3
  } bctrl_state_t;

endpackage

// File: rtl/branch_unit_ctrl_if.sv
// Request, shared-ALU and response signals of the branch sequencer.
// master = the sequencer, slave = decode / ALU / PC-update side.
interface branch_unit_ctrl_if
  import core_pkg::*;
#(
  parameter int XLEN = 32
) ();
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_imm;
  logic            alu_sel;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  alu_op_t         alu_op;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_taken;
  logic [XLEN-1:0] resp_target;
  logic            resp_illegal;
  logic            resp_misaligned;

  modport master (
    input  flush, req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
           alu_result, alu_zero, resp_ready,
    output req_ready, alu_sel, alu_a, alu_b, alu_op,
           resp_valid, resp_taken, resp_target, resp_illegal, resp_misaligned
  );

  modport slave (
    output flush, req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
           alu_result, alu_zero, resp_ready,
    input  req_ready, alu_sel, alu_a, alu_b, alu_op,
           resp_valid, resp_taken, resp_target, resp_illegal, resp_misaligned
  );
endinterface

// File: rtl/branch_unit_ctrl_cond.sv
// Branch condition decode: picks the compare op for a funct3 and turns the
// ALU flags of that compare into the taken decision.
module branch_cond_eval
  import core_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_zero,
  input  logic       i_lt,
  output logic       o_taken,
  output alu_op_t    o_op,
  output logic       o_illegal
);
  always_comb begin
    o_taken   = 1'b0;
    o_op      = ALU_SUB;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:  o_taken = i_zero;
      F3_BNE:  o_taken = ~i_zero;
      F3_BLT:  begin o_op = ALU_SLT;  o_taken = i_lt;  end
      F3_BGE:  begin o_op = ALU_SLT;  o_taken = ~i_lt; end
      F3_BLTU: begin o_op = ALU_SLTU; o_taken = i_lt;  end
      F3_BGEU: begin o_op = ALU_SLTU; o_taken = ~i_lt; end
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/branch_unit_ctrl.sv
// Branch resolution sequencer: borrows the shared ALU for a compare cycle and
// a target-add cycle, then holds the result until the PC logic takes it.
module branch_unit_ctrl
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                clk,
  input logic                rst_n,
  branch_unit_ctrl_if.master bus
);
  bctrl_state_t    r_state;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic            r_req_ready;
  logic            r_alu_sel;
  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  alu_op_t         r_alu_op;
  logic            r_resp_valid;
  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic            r_illegal;
  logic            r_misaligned;

  logic [2:0] w_eval_f3;
  logic       w_taken;
  logic       w_illegal;
  alu_op_t    w_op;

  // In IDLE the decoder looks at the incoming funct3 so the compare op can be
  // registered at accept; from CMP on it looks at the captured one.
  assign w_eval_f3 = (r_state == ST_IDLE) ? bus.req_funct3 : r_funct3;

  branch_cond_eval u_cond (
    .i_funct3  (w_eval_f3),
    .i_zero    (bus.alu_zero),
    .i_lt      (bus.alu_result[0]),
    .o_taken   (w_taken),
    .o_op      (w_op),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_funct3     <= '0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_req_ready  <= 1'b1;
      r_alu_sel    <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= ALU_ADD;
      r_resp_valid <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= '0;
      r_illegal    <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (bus.flush && r_state != ST_IDLE) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_alu_sel    <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= ALU_ADD;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            r_funct3    <= bus.req_funct3;
            r_pc        <= bus.req_pc;
            r_imm       <= bus.req_imm;
            r_req_ready <= 1'b0;
            r_alu_sel   <= 1'b1;
            r_alu_a     <= bus.req_rs1;
            r_alu_b     <= bus.req_rs2;
            r_alu_op    <= w_op;
            r_state     <= ST_CMP;
          end
        end
        ST_CMP: begin
          // Illegal encodings still burn the compare cycle so latency is fixed.
          r_taken   <= w_taken & ~w_illegal;
          r_illegal <= w_illegal;
          r_alu_op  <= ALU_ADD;
          r_alu_a   <= r_pc;
          r_alu_b   <= (w_taken & ~w_illegal) ? r_imm : XLEN'(4);
          r_state   <= ST_TGT;
        end
        ST_TGT: begin
          r_target     <= bus.alu_result;
          r_misaligned <= r_taken && (bus.alu_result[1:0] != 2'b00);
          r_alu_sel    <= 1'b0;
          r_alu_a      <= '0;
          r_alu_b      <= '0;
          r_alu_op     <= ALU_ADD;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready       = r_req_ready;
  assign bus.alu_sel         = r_alu_sel;
  assign bus.alu_a           = r_alu_a;
  assign bus.alu_b           = r_alu_b;
  assign bus.alu_op          = r_alu_op;
  assign bus.resp_valid      = r_resp_valid;
  assign bus.resp_taken      = r_taken;
  assign bus.resp_target     = r_target;
  assign bus.resp_illegal    = r_illegal;
  assign bus.resp_misaligned = r_misaligned;
endmodule

// File: tb/tb_branch_unit_ctrl.sv
// Scoreboarded bench for branch_unit_ctrl with a behavioural shared ALU.
module tb_branch_unit_ctrl;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_unit_ctrl_if #(.XLEN(32)) bif ();
  branch_unit_ctrl #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.master));

  always_comb begin
    case (bif.alu_op)
      ALU_SUB:  bif.alu_result = bif.alu_a - bif.alu_b;
      ALU_SLT:  bif.alu_result = {31'b0, $signed(bif.alu_a) < $signed(bif.alu_b)};
      ALU_SLTU: bif.alu_result = {31'b0, bif.alu_a < bif.alu_b};
      default:  bif.alu_result = bif.alu_a + bif.alu_b;
    endcase
  end
  assign bif.alu_zero = (bif.alu_result == 32'h0);

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        illegal;
    logic        misaligned;
    int          first;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per response handshake.
  initial begin
    logic prev_v;
    int   rise;
    exp_t e;
    prev_v = 1'b0;
    rise   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_v = 1'b0;
      else begin
        if (bif.resp_valid) vcnt++;
        if (bif.resp_valid && !prev_v) begin
          rise = cyc;
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected 0 (cycle %0d)", cyc);
          end
        end
        if (bif.resp_valid && bif.resp_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("resp_taken", 32'(bif.resp_taken), 32'(e.taken));
          chk("resp_target", bif.resp_target, e.target);
          chk("resp_illegal", 32'(bif.resp_illegal), 32'(e.illegal));
          chk("resp_misaligned", 32'(bif.resp_misaligned), 32'(e.misaligned));
          chk("resp_latency", 32'(rise), 32'(e.first));
        end
        prev_v = bif.resp_valid;
      end
    end
  end

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] rs1, rs2, pc, imm);
    bif.req_valid  = 1'b1;
    bif.req_funct3 = f3;
    bif.req_rs1    = rs1;
    bif.req_rs2    = rs2;
    bif.req_pc     = pc;
    bif.req_imm    = imm;
  endtask

  // Issues one request and checks the two ALU-ownership cycles.
  task automatic send(input logic [2:0] f3, input logic [31:0] rs1, rs2, pc, imm,
                      input logic etaken, eill, emis, input logic [31:0] etgt,
                      input alu_op_t eop, input bit chkop);
    @(posedge clk); #1;
    chk("idle_req_ready", 32'(bif.req_ready), 32'd1);
    drive_req(f3, rs1, rs2, pc, imm);
    q.push_back('{etaken, etgt, eill, emis, cyc + 3});
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    chk("cmp_alu_sel", 32'(bif.alu_sel), 32'd1);
    chk("cmp_alu_a", bif.alu_a, rs1);
    chk("cmp_alu_b", bif.alu_b, rs2);
    if (chkop) chk("cmp_alu_op", 32'(bif.alu_op), 32'(eop));
    chk("cmp_req_ready", 32'(bif.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("tgt_alu_op", 32'(bif.alu_op), 32'(ALU_ADD));
    chk("tgt_alu_a", bif.alu_a, pc);
    chk("tgt_alu_b", bif.alu_b, etaken ? imm : 32'd4);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no response expected %0d pending", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int v0;
    logic [31:0] tgt0;
    bif.flush      = 1'b0;
    bif.req_valid  = 1'b0;
    bif.req_funct3 = '0;
    bif.req_rs1    = '0;
    bif.req_rs2    = '0;
    bif.req_pc     = '0;
    bif.req_imm    = '0;
    bif.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bif.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bif.resp_valid), 32'd0);
    chk("rst_alu_sel", 32'(bif.alu_sel), 32'd0);
    chk("rst_alu_a", bif.alu_a, 32'd0);
    chk("rst_alu_op", 32'(bif.alu_op), 32'd0);
    chk("rst_resp_target", bif.resp_target, 32'd0);
    rst_n = 1'b1;

    send(F3_BEQ,  32'h5, 32'h5,         32'h100, 32'h20,        1'b1, 1'b0, 1'b0, 32'h120, ALU_SUB,  1'b1);
    wait_done();
    send(F3_BLTU, 32'h1, 32'hFFFF_FFFF, 32'h200, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 32'h1F8, ALU_SLTU, 1'b1);
    wait_done();
    send(F3_BLT,  32'h1, 32'hFFFF_FFFF, 32'h200, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 32'h204, ALU_SLT,  1'b1);
    wait_done();
    send(3'b010,  32'h7, 32'h7,         32'h300, 32'h40,        1'b0, 1'b1, 1'b0, 32'h304, ALU_SUB,  1'b0);
    wait_done();
    // pc + imm wraps past the top of the address space
    send(F3_BEQ,  32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20, 1'b1, 1'b0, 1'b0, 32'h10, ALU_SUB, 1'b1);
    wait_done();

    // Back-pressure: response must hold while resp_ready is low
    bif.resp_ready = 1'b0;
    send(F3_BNE, 32'h1, 32'h2, 32'h400, 32'h6, 1'b1, 1'b0, 1'b1, 32'h406, ALU_SUB, 1'b1);
    @(posedge clk); #1;
    chk("stall_valid", 32'(bif.resp_valid), 32'd1);
    tgt0 = bif.resp_target;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_hold_valid", 32'(bif.resp_valid), 32'd1);
      chk("stall_hold_target", bif.resp_target, tgt0);
      chk("stall_hold_taken", 32'(bif.resp_taken), 32'd1);
      chk("stall_hold_mis", 32'(bif.resp_misaligned), 32'd1);
      chk("stall_req_ready", 32'(bif.req_ready), 32'd0);
    end
    bif.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_req_ready", 32'(bif.req_ready), 32'd1);
    chk("post_hs_valid", 32'(bif.resp_valid), 32'd0);
    wait_done();

    // Flush during TGT, then a request coinciding with flush in IDLE
    v0 = vcnt;
    @(posedge clk); #1;
    drive_req(F3_BNE, 32'h1, 32'h2, 32'h700, 32'h10);
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_tgt_sel", 32'(bif.alu_sel), 32'd1);
    bif.flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_ready", 32'(bif.req_ready), 32'd1);
    chk("flush_idle_sel", 32'(bif.alu_sel), 32'd0);
    drive_req(F3_BEQ, 32'h3, 32'h3, 32'h800, 32'h8);
    @(posedge clk); #1;
    chk("flush_no_accept", 32'(bif.req_ready), 32'd1);
    chk("flush_no_accept_sel", 32'(bif.alu_sel), 32'd0);
    bif.flush = 1'b0;
    bif.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_no_resp", 32'(vcnt - v0), 32'd0);

    // Asynchronous reset in the middle of CMP
    @(posedge clk); #1;
    drive_req(F3_BEQ, 32'h3, 32'h3, 32'h600, 32'h8);
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    chk("pre_rst_sel", 32'(bif.alu_sel), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(bif.req_ready), 32'd1);
    chk("arst_alu_sel", 32'(bif.alu_sel), 32'd0);
    chk("arst_alu_a", bif.alu_a, 32'd0);
    chk("arst_alu_b", bif.alu_b, 32'd0);
    chk("arst_alu_op", 32'(bif.alu_op), 32'd0);
    chk("arst_resp_valid", 32'(bif.resp_valid), 32'd0);
    #3 rst_n = 1'b1;
    v0 = vcnt;
    repeat (4) @(posedge clk);
    #1;
    chk("arst_no_resp", 32'(vcnt - v0), 32'd0);
    send(F3_BGE, 32'hFFFF_FFFF, 32'h0, 32'h500, 32'h40, 1'b0, 1'b0, 1'b0, 32'h504, ALU_SLT, 1'b1);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
